// File: rtl/rf_read_arbiter_if.sv
// Request/grant bundle between operand-collector request logic and the
// register-file read arbiter.
interface rf_read_arbiter_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          req_valid;
  logic [1:0]    req_ocid;
  logic [2:0]    req_rowid_a;
  logic [2:0]    req_rowid_b;
  logic [1:0]    req_bankid_a;
  logic [1:0]    req_bankid_b;
  logic          req_ready;
  logic [3:0]    bank_rd_en;
  logic [11:0]   bank_rd_row;
  logic [3:0]    gnt_valid;
  logic [7:0]    gnt_ocid;
  logic [3:0]    gnt_opsel;
  logic [CW-1:0] fifo_count;

  modport master (
    output req_valid, req_ocid, req_rowid_a, req_rowid_b, req_bankid_a, req_bankid_b,
    input  req_ready, bank_rd_en, bank_rd_row, gnt_valid, gnt_ocid, gnt_opsel, fifo_count
  );

  modport slave (
    input  req_valid, req_ocid, req_rowid_a, req_rowid_b, req_bankid_a, req_bankid_b,
    output req_ready, bank_rd_en, bank_rd_row, gnt_valid, gnt_ocid, gnt_opsel, fifo_count
  );
endinterface

// File: rtl/rf_read_arbiter.sv
// Two-operand register-file read arbiter: in-order request queue, per-bank
// oldest-first grant, registered grant lanes aligned with 1-cycle bank data.
module rf_read_arbiter #(
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  rf_read_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NB = 4;

  // Request payload; only the pending flags need reset.
  logic [1:0] ocid_mem   [DEPTH];
  logic [2:0] row_a_mem  [DEPTH];
  logic [2:0] row_b_mem  [DEPTH];
  logic [1:0] bank_a_mem [DEPTH];
  logic [1:0] bank_b_mem [DEPTH];

  logic [DEPTH-1:0] pend_a_reg, pend_b_reg, pend_a_next, pend_b_next;
  logic [DEPTH-1:0] grant_a, grant_b;
  logic [PW-1:0]    head_reg, tail_reg;
  logic [CW-1:0]    count_reg, count_next;
  logic             push, pop;

  logic [DEPTH-1:0] hit_a [NB];
  logic [DEPTH-1:0] hit_b [NB];
  logic [NB-1:0]    lane_en, lane_op;
  logic [3*NB-1:0]  lane_row;
  logic [2*NB-1:0]  lane_oc;

  logic [NB-1:0]    gnt_valid_reg, gnt_opsel_reg;
  logic [2*NB-1:0]  gnt_ocid_reg;

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_bank
      logic             found_l;
      logic [PW-1:0]    idx_l;
      logic [DEPTH-1:0] hit_a_l, hit_b_l;
      logic             en_l, op_l;
      logic [2:0]       row_l;
      logic [1:0]       oc_l;

      // Walk the queue from the head; the first pending operand for this
      // bank wins, operand a checked before operand b within an entry.
      always_comb begin
        found_l = 1'b0;
        idx_l   = head_reg;
        hit_a_l = '0;
        hit_b_l = '0;
        en_l    = 1'b0;
        op_l    = 1'b0;
        row_l   = '0;
        oc_l    = '0;
        for (int k = 0; k < DEPTH; k++) begin
          idx_l = head_reg + PW'(k);
          if (!found_l && (CW'(k) < count_reg)) begin
            if (pend_a_reg[idx_l] && (bank_a_mem[idx_l] == 2'(gi))) begin
              found_l        = 1'b1;
              hit_a_l[idx_l] = 1'b1;
              en_l           = 1'b1;
              row_l          = row_a_mem[idx_l];
              oc_l           = ocid_mem[idx_l];
            end else if (pend_b_reg[idx_l] && (bank_b_mem[idx_l] == 2'(gi))) begin
              found_l        = 1'b1;
              hit_b_l[idx_l] = 1'b1;
              en_l           = 1'b1;
              op_l           = 1'b1;
              row_l          = row_b_mem[idx_l];
              oc_l           = ocid_mem[idx_l];
            end
          end
        end
      end

      assign hit_a[gi]           = hit_a_l;
      assign hit_b[gi]           = hit_b_l;
      assign lane_en[gi]         = en_l;
      assign lane_op[gi]         = op_l;
      assign lane_row[3*gi +: 3] = row_l;
      assign lane_oc[2*gi +: 2]  = oc_l;
    end
  endgenerate

  always_comb begin
    grant_a = '0;
    grant_b = '0;
    for (int b = 0; b < NB; b++) begin
      grant_a = grant_a | hit_a[b];
      grant_b = grant_b | hit_b[b];
    end
  end

  // Pop decision uses flags after this cycle's grants; the push slot can
  // never alias an occupied entry because pushes are refused when full.
  always_comb begin
    pend_a_next = pend_a_reg & ~grant_a;
    pend_b_next = pend_b_reg & ~grant_b;
    pop  = (count_reg != '0) && !pend_a_next[head_reg] && !pend_b_next[head_reg];
    push = bus.req_valid && bus.req_ready;
    if (push) begin
      pend_a_next[tail_reg] = 1'b1;
      pend_b_next[tail_reg] = 1'b1;
    end
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (pop && !push) begin
      count_next = count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      pend_a_reg    <= '0;
      pend_b_reg    <= '0;
      gnt_valid_reg <= '0;
      gnt_opsel_reg <= '0;
      gnt_ocid_reg  <= '0;
    end else begin
      head_reg      <= head_reg + PW'(pop);
      tail_reg      <= tail_reg + PW'(push);
      count_reg     <= count_next;
      pend_a_reg    <= pend_a_next;
      pend_b_reg    <= pend_b_next;
      gnt_valid_reg <= lane_en;
      gnt_opsel_reg <= lane_op;
      gnt_ocid_reg  <= lane_oc;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ocid_mem[tail_reg]   <= bus.req_ocid;
      row_a_mem[tail_reg]  <= bus.req_rowid_a;
      row_b_mem[tail_reg]  <= bus.req_rowid_b;
      bank_a_mem[tail_reg] <= bus.req_bankid_a;
      bank_b_mem[tail_reg] <= bus.req_bankid_b;
    end
  end

  assign bus.req_ready   = (count_reg < CW'(DEPTH));
  assign bus.fifo_count  = count_reg;
  assign bus.bank_rd_en  = lane_en;
  assign bus.bank_rd_row = lane_row;
  assign bus.gnt_valid   = gnt_valid_reg;
  assign bus.gnt_ocid    = gnt_ocid_reg;
  assign bus.gnt_opsel   = gnt_opsel_reg;
endmodule

// File: tb/tb_rf_read_arbiter.sv
// Bench for rf_read_arbiter: directed scenarios plus random traffic, compared
// cycle by cycle against a queue-based reference model.
module tb_rf_read_arbiter;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rf_read_arbiter_if #(.DEPTH(DEPTH)) bus ();
  rf_read_arbiter #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] oc;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [1:0] ba;
    logic [1:0] bb;
    bit         pa;
    bit         pb;
  } ent_t;

  ent_t q[$];
  int total = 0;
  int bad = 0;
  int gnt_seen = 0;
  int sent = 0;

  logic [3:0]  cur_en, cur_op, prv_en, prv_op;
  logic [11:0] cur_row;
  logic [7:0]  cur_oc, prv_oc;
  int          cur_i [4];
  bit          cur_b [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference rule: per bank, oldest entry with a pending operand on that
  // bank wins; a beats b inside one entry.
  task automatic model_arb();
    cur_en = '0; cur_op = '0; cur_row = '0; cur_oc = '0;
    for (int b = 0; b < 4; b++) begin
      cur_i[b] = -1;
      cur_b[b] = 1'b0;
      for (int i = 0; i < q.size(); i++) begin
        if (q[i].pa && q[i].ba == 2'(b)) begin cur_i[b] = i; cur_b[b] = 1'b0; break; end
        if (q[i].pb && q[i].bb == 2'(b)) begin cur_i[b] = i; cur_b[b] = 1'b1; break; end
      end
      if (cur_i[b] >= 0) begin
        cur_en[b]          = 1'b1;
        cur_op[b]          = cur_b[b];
        cur_row[3*b +: 3]  = cur_b[b] ? q[cur_i[b]].rb : q[cur_i[b]].ra;
        cur_oc[2*b +: 2]   = q[cur_i[b]].oc;
      end
    end
  endtask

  task automatic cycle(input bit v, input logic [1:0] oc, input logic [2:0] ra, input logic [2:0] rb,
                       input logic [1:0] ba, input logic [1:0] bb);
    int  n_before;
    bit  acc;
    bus.req_valid    = v;
    bus.req_ocid     = oc;
    bus.req_rowid_a  = ra;
    bus.req_rowid_b  = rb;
    bus.req_bankid_a = ba;
    bus.req_bankid_b = bb;
    model_arb();
    n_before = q.size();
    chk("req_ready", bus.req_ready, (n_before < DEPTH));
    chk("fifo_count", bus.fifo_count, n_before);
    chk("bank_rd_en", bus.bank_rd_en, cur_en);
    chk("bank_rd_row", bus.bank_rd_row, cur_row);
    chk("gnt_valid", bus.gnt_valid, prv_en);
    chk("gnt_ocid", bus.gnt_ocid, prv_oc);
    chk("gnt_opsel", bus.gnt_opsel, prv_op);
    gnt_seen += $countones(bus.gnt_valid);
    acc = v && (n_before < DEPTH);
    $display("cyc t=%0t v=%0b acc=%0b cnt=%0d rd_en=%b gnt=%b", $time, v, acc, n_before, bus.bank_rd_en, bus.gnt_valid);
    @(posedge clk);
    #1;
    for (int b = 0; b < 4; b++) begin
      if (cur_en[b]) begin
        if (cur_b[b]) q[cur_i[b]].pb = 1'b0;
        else          q[cur_i[b]].pa = 1'b0;
      end
    end
    if (q.size() > 0 && !q[0].pa && !q[0].pb) void'(q.pop_front());
    if (acc) q.push_back('{oc, ra, rb, ba, bb, 1'b1, 1'b1});
    prv_en = cur_en; prv_oc = cur_oc; prv_op = cur_op;
    bus.req_valid = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, 2'd0, 3'd0, 3'd0, 2'd0, 2'd0);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_ocid = '0; bus.req_rowid_a = '0; bus.req_rowid_b = '0;
    bus.req_bankid_a = '0; bus.req_bankid_b = '0;
    prv_en = '0; prv_oc = '0; prv_op = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", bus.req_ready, 1'b1);
    chk("rst_count", bus.fifo_count, 0);
    chk("rst_rd_en", bus.bank_rd_en, 4'b0000);
    chk("rst_rd_row", bus.bank_rd_row, 12'h000);
    chk("rst_gnt_valid", bus.gnt_valid, 4'b0000);
    rst = 1'b0;

    // Two operands on distinct banks
    cycle(1'b1, 2'd2, 3'd5, 3'd2, 2'd1, 2'd3);
    chk("t1_rd_en", bus.bank_rd_en, 4'b1010);
    chk("t1_rd_row", bus.bank_rd_row, 12'h428);
    chk("t1_count1", bus.fifo_count, 1);
    idle();
    chk("t1_gnt_valid", bus.gnt_valid, 4'b1010);
    chk("t1_gnt_ocid", bus.gnt_ocid, 8'h88);
    chk("t1_gnt_opsel", bus.gnt_opsel, 4'b1000);
    chk("t1_count0", bus.fifo_count, 0);
    idle();

    // Both operands on the same bank: a first, then b
    cycle(1'b1, 2'd0, 3'd1, 3'd4, 2'd2, 2'd2);
    chk("t2_rd_row_a", bus.bank_rd_row, 12'h040);
    idle();
    chk("t2_rd_row_b", bus.bank_rd_row, 12'h100);
    chk("t2_opsel_a", bus.gnt_opsel, 4'b0000);
    chk("t2_count_mid", bus.fifo_count, 1);
    idle();
    chk("t2_opsel_b", bus.gnt_opsel, 4'b0100);
    chk("t2_count_end", bus.fifo_count, 0);
    idle();

    // Back-to-back entries sharing bank0
    cycle(1'b1, 2'd1, 3'd3, 3'd6, 2'd0, 2'd1);
    cycle(1'b1, 2'd3, 3'd2, 3'd7, 2'd0, 2'd2);
    repeat (3) idle();

    // Fill with all-bank0 requests; refusals when full checked by the model
    for (int i = 0; i < 10; i++) cycle(1'b1, 2'(i), 3'(i), 3'(i + 3), 2'd0, 2'd0);
    for (int c = 0; c < 30 && q.size() > 0; c++) idle();
    chk("fill_drained", bus.fifo_count, 0);
    idle();

    // Reset mid-stream with three entries queued
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'd3, 3'(i + 1), 3'(i + 4), 2'd0, 2'd0);
    #2 rst = 1'b1;
    #1;
    chk("mrst_rd_en", bus.bank_rd_en, 4'b0000);
    chk("mrst_rd_row", bus.bank_rd_row, 12'h000);
    chk("mrst_gnt_valid", bus.gnt_valid, 4'b0000);
    chk("mrst_gnt_ocid", bus.gnt_ocid, 8'h00);
    chk("mrst_gnt_opsel", bus.gnt_opsel, 4'b0000);
    chk("mrst_count", bus.fifo_count, 0);
    chk("mrst_ready", bus.req_ready, 1'b1);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    prv_en = '0; prv_oc = '0; prv_op = '0;
    chk("post_rst_gnt_valid", bus.gnt_valid, 4'b0000);
    idle();
    idle();

    // Random traffic with pointer wrap
    gnt_seen = 0;
    sent = 0;
    for (int c = 0; c < 400 && sent < 20; c++) begin
      bit v;
      v = 1'($urandom_range(0, 1));
      if (v && q.size() < DEPTH) sent++;
      cycle(v, 2'($urandom), 3'($urandom), 3'($urandom), 2'($urandom), 2'($urandom));
    end
    for (int c = 0; c < 200 && q.size() > 0; c++) idle();
    idle();
    chk("rand_sent", sent, 20);
    chk("rand_grants", gnt_seen, 40);
    chk("rand_drained", bus.fifo_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
